// File: rtl/dna_mem_reader_if.sv
// rtl/dna_mem_reader_if.sv - handshake and bus bundle for the DNA register file burst reader
//
// Purpose: groups the burst control, register file read port and output stream
// signals of dna_mem_reader into one interface.
// Optional feature macro: DNA_READER_REVERSE_EN adds the 'reverse' control bit.
//
// Signals:
//   start, base_addr[31:0], length[7:0]  burst request (driven by the requester)
//   reverse                              descending address order (macro only)
//   busy, done                           burst status (driven by the reader)
//   mem_r_addr[31:0]                     register file read address (reader)
//   mem_r_data[DATA_WIDTH-1:0]           register file read data (register file)
//   m_data, m_valid, m_last              output stream (reader)
//   m_ready                              output stream ready (consumer)
//
// Modports: master = reader side, slave = environment side.
interface dna_mem_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [31:0]           base_addr;
    logic [7:0]            length;
`ifdef DNA_READER_REVERSE_EN
    logic                  reverse;
`endif
    logic                  busy;
    logic                  done;
    logic [31:0]           mem_r_addr;
    logic [DATA_WIDTH-1:0] mem_r_data;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
`ifdef DNA_READER_REVERSE_EN
        input  reverse,
`endif
        input  start, base_addr, length, mem_r_data, m_ready,
        output busy, done, mem_r_addr, m_data, m_valid, m_last
    );

    modport slave (
`ifdef DNA_READER_REVERSE_EN
        output reverse,
`endif
        output start, base_addr, length, mem_r_data, m_ready,
        input  busy, done, mem_r_addr, m_data, m_valid, m_last
    );
endinterface

// File: rtl/dna_mem_reader.sv
// rtl/dna_mem_reader.sv - burst read engine for the 128-entry DNA register file
//
// Purpose: on a start pulse walks a wrapping address range over the register
// file's synchronous read port and streams the returned words out through a
// 2-entry buffer that absorbs downstream backpressure without losing data.
// Optional feature macro: DNA_READER_REVERSE_EN (descending address order).
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   dna_mem_reader_if.master: start/base_addr/length(/reverse) request,
//         busy/done status, mem_r_addr/mem_r_data read port,
//         m_data/m_valid/m_ready/m_last output stream
module dna_mem_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128
) (
    input  logic             clk,
    input  logic             rst,
    dna_mem_reader_if.master bus
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [7:0] LEN_MAX = 8'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  zero_pend_q;     // zero-length request: done follows next cycle
    logic                  first_q;         // first RUN cycle issues nothing (address lands in cycle 1)
    logic [AW-1:0]         base_q;
    logic [AW-1:0]         addr_q;          // last issued address, held between issues
    logic [7:0]            len_q;
    logic [7:0]            idx_q;           // number of reads issued so far
    logic                  rev_q;
    logic                  inflight_q;      // read issued last cycle, data on mem_r_data now
    logic                  inflight_last_q; // ... and it is the final word of the burst
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [1:0]            buf_last_q;
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            count_q;

    logic                  head_valid;
    logic                  head_last;
    logic                  pop;
    logic                  issue;
    logic                  issue_last;
    logic [2:0]            occ;
    logic [AW-1:0]         offset;
    logic [AW-1:0]         addr_d;
    logic [7:0]            len_d;
    logic                  rev_d;
    logic                  unused_base_hi;

    assign unused_base_hi = ^bus.base_addr[31:AW];

`ifdef DNA_READER_REVERSE_EN
    assign rev_d = bus.reverse;
`else
    assign rev_d = 1'b0;
`endif

    always_comb begin
        len_d      = (bus.length > LEN_MAX) ? LEN_MAX : bus.length;
        head_valid = (count_q != 2'd0);
        head_last  = head_valid && buf_last_q[rd_ptr_q];
        pop        = head_valid && bus.m_ready;
        // Occupancy the buffer will have once the read now in flight lands;
        // issuing only while this is <= 1 guarantees the new word has a slot.
        occ        = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        issue      = (state_q == S_RUN) && !first_q && (idx_q < len_q) && (occ <= 3'd1);
        issue_last = (idx_q == len_q - 8'd1);
        offset     = idx_q[AW-1:0];
        addr_d     = rev_q ? (base_q - offset) : (base_q + offset);
    end

    // The read address is presented in the same cycle the issue decision is made,
    // because that decision depends on this cycle's m_ready.
    assign bus.mem_r_addr = 32'(issue ? addr_d : addr_q);
    assign bus.m_valid    = head_valid;
    assign bus.m_data     = head_valid ? buf_data_q[rd_ptr_q] : '0;
    assign bus.m_last     = head_last;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            zero_pend_q     <= 1'b0;
            first_q         <= 1'b0;
            base_q          <= '0;
            addr_q          <= '0;
            len_q           <= '0;
            idx_q           <= '0;
            rev_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_last_q      <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
            end
        end else begin
            done_q          <= zero_pend_q;
            zero_pend_q     <= 1'b0;
            first_q         <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue && issue_last;

            if (issue) begin
                addr_q <= addr_d;
                idx_q  <= idx_q + 8'd1;
            end

            if (inflight_q) begin
                buf_data_q[wr_ptr_q] <= bus.mem_r_data;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(inflight_q) - 2'(pop);

            case (state_q)
                S_IDLE: begin
                    if (bus.start && !done_q && !zero_pend_q) begin
                        if (len_d == 8'd0) begin
                            zero_pend_q <= 1'b1;
                        end else begin
                            base_q  <= bus.base_addr[AW-1:0];
                            len_q   <= len_d;
                            idx_q   <= 8'd0;
                            rev_q   <= rev_d;
                            first_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (issue && issue_last) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The last word leaving means the buffer is empty and nothing is in flight.
                    if (pop && head_last) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/dna_mem_reader.md
# dna_mem_reader

Burst read engine for the 128-entry DNA register file. On a start pulse it walks a contiguous, wrapping address range, drives the register file's synchronous read port, and presents the returned words as a valid/ready stream with a last-word flag. It sits between the register file and downstream DNA processing stages and absorbs downstream backpressure with a 2-entry output buffer, so no read data is lost.

## Interface
- `DATA_WIDTH`, 32, width of the register file word and of the stream data.
- `DEPTH`, 128, number of register file entries; addresses wrap modulo `DEPTH`.
- `clk` input 1: sole clock; every register updates on the rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `start` input 1: burst request, sampled only in IDLE.
- `base_addr` input 32: first address; only bits [6:0] are used (value mod `DEPTH`).
- `length` input 8: word count, 0..`DEPTH`; values above `DEPTH` are clamped to `DEPTH`.
- `busy` output 1: high in RUN and DRAIN.
- `done` output 1: one-cycle pulse marking the end of a burst.
- `mem_r_addr` output 32: register file read address, zero-extended.
- `mem_r_data` input `DATA_WIDTH`: register file read data, valid one cycle after the address.
- `m_data` output `DATA_WIDTH`: stream data.
- `m_valid` output 1: stream valid.
- `m_ready` input 1: stream ready.
- `m_last` output 1: high with the final word of the burst.

## Operation
- States:
  - IDLE: `start`=1 latches `base_addr`[6:0], the clamped `length` and `reverse` (if configured), then goes to RUN. If `length`=0 it instead pulses `done` next cycle and stays in IDLE.
  - RUN: issues reads and moves to DRAIN after the last issue.
  - DRAIN: moves to IDLE once the buffer is empty and no read is in flight.
- Issue rule, evaluated in RUN with words remaining: issue in cycle t iff `count(t) + inflight(t) - pop(t) <= 1`.
  - `count` is the buffer occupancy (0..2).
  - `inflight` is a register that is set when a read was issued in the previous cycle.
  - `pop` is `m_valid & m_ready`.
- Issuing drives `mem_r_addr` = (base + i) mod `DEPTH` for word index i = 0..length-1. Between issues, `mem_r_addr` holds its last value.
- When `inflight`=1, `mem_r_data` is written to the buffer tail that cycle. The buffer never overflows.
- Stream output:
  - `m_data`, `m_valid` and `m_last` come from the buffer head.
  - A word is transferred on a cycle with `m_valid & m_ready`.
  - While `m_valid`=1 and `m_ready`=0, the head must stay stable.
- `m_last` is set on the word with index length-1 only.
- `done` pulses in the cycle after the `m_last` handshake. The state is IDLE and `busy` is 0 in that cycle.
- `start` is ignored while `busy`=1 and also in the `done` cycle.
- `rst` mid-burst: on the next edge the block is in IDLE, the buffer and `inflight` are cleared, and returning read data is discarded.
- Reset values: `busy`=0, `done`=0, `mem_r_addr`=0, `m_data`=0, `m_valid`=0, `m_last`=0.

## Timing
- The edge that samples `start` is edge 0; cycle k is the cycle that follows edge k.
- First address appears on `mem_r_addr` in cycle 1. Its data appears on `mem_r_data` in cycle 2 and is captured at edge 3.
- First `m_valid` is in cycle 3, a latency of 3 cycles.
- With `m_ready` held at 1, there is one address per cycle and one word per cycle, with no bubbles.
- An N-word burst has its last word in cycle N+2 and `done` in cycle N+3.
- `length`=0 gives `done` in cycle 1.

## Configuration
- Macro: `DNA_READER_REVERSE_EN`.
- Defined:
  - Adds input `reverse` (1 bit), sampled with `start`.
  - When `reverse`=1, the address sequence is (base - i) mod `DEPTH`, descending and wrapping from 0 to `DEPTH`-1.
  - When `reverse`=0, the sequence ascends as normal.
- Undefined: the port is absent and the sequence always ascends.

## Test plan
Preload the register file with mem[a] = a*3 + 5 for all tests.

- Basic burst: `base_addr`=0, `length`=4, `m_ready`=1 -> `m_data` is 5, 8, 11, 14 in cycles 3..6, `m_last` is high in cycle 6 only, and `done` is high in cycle 7.
- Wrap-around: `base_addr`=126, `length`=4 -> `mem_r_addr` is 126, 127, 0, 1 and the data is 383, 386, 5, 8.
- Backpressure: `base_addr`=10, `length`=8, `m_ready`=0 for cycles 3..9 -> `m_data` holds 35 throughout the stall and at most 2 reads complete before the stall. After releasing `m_ready`, exactly 35, 38, ..., 56 arrive, with no loss or duplication.
- Edge lengths:
  - `length`=0 -> `done` in cycle 1 and `m_valid` never asserts.
  - `length`=200 -> 128 words and `m_last` on word 127.
- Reset mid-burst: assert `rst` in cycle 4 of a 16-word burst -> all outputs are 0 in cycle 5. A new burst with `base_addr`=2, `length`=2 then yields 11, 14 with normal timing.
- `DNA_READER_REVERSE_EN` defined, `reverse`=1, `base_addr`=1, `length`=3 -> `mem_r_addr` is 1, 0, 127 and the data is 8, 5, 386.
